task_frame_buffer: RTL and testbench

Parametrised multi-frame input buffer for the task datapath, next generation of the single-frame task input stage. It accepts frames on a valid/last input stream into NUM_FRAMES fixed slots of an internal synchronous-read memory (no vendor FIFO primitive), then replays complete frames in arrival order on a valid/ready/last output stream at full throughput. Oversize frames are detected and flagged, and the input accepts a new frame while earlier frames drain.

---
 rtl/task_frame_buffer_if.sv | 28 ++
 rtl/task_frame_buffer.sv | 157 +++++++++++++++
 tb/tb_task_frame_buffer.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/task_frame_buffer_if.sv
// Stream bundle for task_frame_buffer: input frame stream, output frame stream and buffer status.
interface task_frame_buffer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_FRAMES = 2
);
   localparam int FW = $clog2(NUM_FRAMES + 1);

   logic                  i_tdata_valid;
   logic [DATA_WIDTH-1:0] i_tdata;
   logic                  i_tdata_last;
   logic                  o_tready;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_enb;
   logic                  o_last;
   logic                  i_out_ready;
   logic [FW-1:0]         o_frames;
   logic                  o_overflow;

   modport master (
      output i_tdata_valid, i_tdata, i_tdata_last, i_out_ready,
      input  o_tready, o_data, o_enb, o_last, o_frames, o_overflow
   );

   modport slave (
      input  i_tdata_valid, i_tdata, i_tdata_last, i_out_ready,
      output o_tready, o_data, o_enb, o_last, o_frames, o_overflow
   );
endinterface

// File: rtl/task_frame_buffer.sv
// Multi-slot frame buffer: loads valid/last frames into NUM_FRAMES slots and replays them in arrival order.
// Define TASK_FRAME_BUF_DROP_EN to drop oversize frames; by default they are truncated to NUM_WORDS.
module task_frame_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_WORDS  = 243,
   parameter int NUM_FRAMES = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   task_frame_buffer_if.slave bus
);

   localparam int SW    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int IW    = $clog2(NUM_WORDS + 1);
   localparam int FW    = $clog2(NUM_FRAMES + 1);
   localparam int DEPTH = NUM_FRAMES * NUM_WORDS;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] W_IDLE    = 2'd0;
   localparam logic [1:0] W_LOAD    = 2'd1;
   localparam logic [1:0] W_DISCARD = 2'd2;

   logic [DATA_WIDTH-1:0] mem   [DEPTH];
   logic [IW-1:0]         len_q [NUM_FRAMES];

   logic [1:0]            w_state_q, w_state_d;
   logic [SW-1:0]         wr_slot_q, wr_slot_d;
   logic [IW-1:0]         wr_idx_q, wr_idx_d;
   logic [FW-1:0]         frames_q, frames_d;
   logic [FW-1:0]         pend_q, pend_d;
   logic [SW-1:0]         rd_slot_q, rd_slot_d;
   logic [IW-1:0]         rd_idx_q, rd_idx_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  enb_q, enb_d, last_q, ovf_q, ovf_d, rdy_en_q;

   logic                  accept, wr_en, commit, rd_fire, rd_last, consume, rel;
   logic [IW-1:0]         commit_len;
   logic [AW-1:0]         wr_addr, rd_addr;

   function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
      return (s == SW'(NUM_FRAMES - 1)) ? '0 : s + SW'(1);
   endfunction

   // Input stalls only when idle with every slot holding an unconsumed frame.
   assign bus.o_tready = rdy_en_q && ((w_state_q != W_IDLE) || (frames_q < FW'(NUM_FRAMES)));
   assign accept       = bus.i_tdata_valid && bus.o_tready;
   assign wr_addr      = AW'(wr_slot_q) * AW'(NUM_WORDS) + AW'(wr_idx_q);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_state_d  = w_state_q;
      wr_slot_d  = wr_slot_q;
      wr_idx_d   = wr_idx_q;
      wr_en      = 1'b0;
      commit     = 1'b0;
      commit_len = wr_idx_q + IW'(1);
      ovf_d      = 1'b0;
      if (accept) begin
         if (w_state_q == W_DISCARD) begin
            if (bus.i_tdata_last) begin
               w_state_d = W_IDLE;
               wr_idx_d  = '0;
               ovf_d     = 1'b1;
`ifndef TASK_FRAME_BUF_DROP_EN
               commit     = 1'b1;
               commit_len = IW'(NUM_WORDS);
`endif
            end
         end else begin
            wr_en = 1'b1;
            if (bus.i_tdata_last) begin
               commit    = 1'b1;
               w_state_d = W_IDLE;
               wr_idx_d  = '0;
            end else if (wr_idx_q == IW'(NUM_WORDS - 1)) begin
               w_state_d = W_DISCARD;
            end else begin
               w_state_d = W_LOAD;
               wr_idx_d  = wr_idx_q + IW'(1);
            end
         end
      end
      if (commit) wr_slot_d = slot_inc(wr_slot_q);
   end

   assign rd_addr = AW'(rd_slot_q) * AW'(NUM_WORDS) + AW'(rd_idx_q);
   assign rd_last = (rd_idx_q == len_q[rd_slot_q] - IW'(1));
   assign consume = enb_q && bus.i_out_ready;
   assign rel     = consume && last_q;
   // pend_q counts committed frames with words still to issue; frames_q counts until the last handshake.
   assign rd_fire = (pend_q != '0) && (!enb_q || bus.i_out_ready);

   always_comb begin
      rd_slot_d = rd_slot_q;
      rd_idx_d  = rd_idx_q;
      enb_d     = enb_q;
      if (rd_fire) begin
         enb_d = 1'b1;
         if (rd_last) begin
            rd_idx_d  = '0;
            rd_slot_d = slot_inc(rd_slot_q);
         end else begin
            rd_idx_d = rd_idx_q + IW'(1);
         end
      end else if (consume) begin
         enb_d = 1'b0;
      end
      frames_d = frames_q + FW'(commit) - FW'(rel);
      pend_d   = pend_q + FW'(commit) - FW'(rd_fire && rd_last);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         w_state_q <= W_IDLE;
         wr_slot_q <= '0;
         wr_idx_q  <= '0;
         frames_q  <= '0;
         pend_q    <= '0;
         rd_slot_q <= '0;
         rd_idx_q  <= '0;
         data_q    <= '0;
         enb_q     <= 1'b0;
         last_q    <= 1'b0;
         ovf_q     <= 1'b0;
         rdy_en_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         wr_slot_q <= wr_slot_d;
         wr_idx_q  <= wr_idx_d;
         frames_q  <= frames_d;
         pend_q    <= pend_d;
         rd_slot_q <= rd_slot_d;
         rd_idx_q  <= rd_idx_d;
         enb_q     <= enb_d;
         ovf_q     <= ovf_d;
         rdy_en_q  <= 1'b1;
         if (rd_fire) begin
            data_q <= mem[rd_addr];
            last_q <= rd_last;
         end
      end
   end

   // NOTE: the frame store and length table carry no reset; a slot is only read after it is committed.
   always_ff @(posedge i_clk) begin
      if (wr_en)  mem[wr_addr]     <= bus.i_tdata;
      if (commit) len_q[wr_slot_q] <= commit_len;
   end

   assign bus.o_data     = data_q;
   assign bus.o_enb      = enb_q;
   assign bus.o_last     = last_q;
   assign bus.o_frames   = frames_q;
   assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_task_frame_buffer.sv
// Bench for task_frame_buffer (NUM_WORDS=8, NUM_FRAMES=2): random frames against a queue-based frame model.
// Honours TASK_FRAME_BUF_DROP_EN so the model matches the build under test.
module tb_task_frame_buffer;

   localparam int DW = 8;
   localparam int NW = 8;
   localparam int NF = 2;
`ifdef TASK_FRAME_BUF_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   task_frame_buffer_if #(.DATA_WIDTH(DW), .NUM_FRAMES(NF)) bus ();

   task_frame_buffer #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .NUM_FRAMES(NF)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   int         checks   = 0;
   int         failures = 0;
   int         ovf_cnt  = 0;
   int         exp_ovf  = 0;
   logic [7:0] frm[$];
   logic [8:0] exp_q[$];

   always @(posedge i_clk) if (bus.o_overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;

   task automatic gen_frame(input int len, input bit counting);
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(counting ? 8'(i + 1) : 8'($urandom_range(255)));
   endtask

   // Frame-level model: short frames pass whole; oversize ones are truncated or dropped.
   task automatic model_frame();
      int n = frm.size();
      if (n > NW) begin
         exp_ovf++;
         n = DROP ? 0 : NW;
      end
      for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), frm[i]});
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_frame(input bit with_last, input int gap_pct);
      int i = 0;
      int guard = 0;
      bit acc;
      while (i < frm.size()) begin
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.i_tdata_valid = 1'b0;
            bus.i_tdata_last  = 1'b0;
            acc = 1'b0;
         end else begin
            bus.i_tdata_valid = 1'b1;
            bus.i_tdata       = frm[i];
            bus.i_tdata_last  = with_last && (i == frm.size() - 1);
            acc = bus.o_tready;
         end
         step();
         if (acc) i++;
         else begin
            guard++;
            if (guard > 3000) begin
               checks++;
               failures++;
               $display("FAIL send_timeout: sent %0d of %0d words", i, frm.size());
               break;
            end
         end
      end
      bus.i_tdata_valid = 1'b0;
      bus.i_tdata_last  = 1'b0;
   endtask

   task automatic collect(input int n, input int pct, input bit contig, input string tag);
      int got = 0;
      int cyc = 0;
      int bubbles = 0;
      bit rdy;
      bit hold = 1'b0;
      bit started = 1'b0;
      logic [8:0] held = '0;
      logic [8:0] obs;
      logic [8:0] exp;
      while (got < n && cyc < 4000) begin
         rdy = ($urandom_range(99) < pct);
         bus.i_out_ready = rdy;
         obs = {bus.o_last, bus.o_data};
         if (hold) begin
            checks++;
            if (bus.o_enb !== 1'b1 || obs !== held) begin
               failures++;
               $display("FAIL %s_hold: got enb=%b last_data=%h, required enb=1 last_data=%h", tag, bus.o_enb, obs, held);
            end
         end
         if (contig && started && bus.o_enb !== 1'b1) bubbles++;
         hold = 1'b0;
         if (bus.o_enb === 1'b1) begin
            started = 1'b1;
            if (rdy) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL %s_extra: got last_data=%h, required no word", tag, obs);
               end else begin
                  exp = exp_q.pop_front();
                  if (obs !== exp) begin
                     failures++;
                     $display("FAIL %s_word%0d: got last_data=%h, required %h", tag, got, obs, exp);
                  end
               end
               got++;
            end else begin
               hold = 1'b1;
               held = obs;
            end
         end
         step();
         cyc++;
      end
      bus.i_out_ready = 1'b0;
      checks++;
      if (got < n) begin
         failures++;
         $display("FAIL %s_timeout: got %0d words, required %0d", tag, got, n);
      end
      if (contig) begin
         checks++;
         if (bubbles != 0) begin
            failures++;
            $display("FAIL %s_bubbles: got %0d idle cycles, required 0", tag, bubbles);
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag, input bit tready_exp);
      checks++;
      if (bus.o_tready !== tready_exp || bus.o_enb !== 1'b0 || bus.o_data !== '0 ||
          bus.o_last !== 1'b0 || bus.o_frames !== '0 || bus.o_overflow !== 1'b0) begin
         failures++;
         $display("FAIL %s: got tready=%b enb=%b data=%h last=%b frames=%0d ovf=%b, required tready=%b and the rest 0",
                  tag, bus.o_tready, bus.o_enb, bus.o_data, bus.o_last, bus.o_frames, bus.o_overflow, tready_exp);
      end
   endtask

   task automatic test_reset();
      bus.i_tdata_valid = 1'b0;
      bus.i_tdata       = '0;
      bus.i_tdata_last  = 1'b0;
      bus.i_out_ready   = 1'b0;
      i_rst_n = 1'b0;
      step();
      step();
      check_idle_outputs("reset_state", 1'b0);
      i_rst_n = 1'b1;
      step();
      checks++;
      if (bus.o_tready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_tready: got %b, required 1", bus.o_tready);
      end
   endtask

   task automatic test_single_frame();
      logic [8:0] exp;
      gen_frame(5, 1'b1);
      model_frame();
      send_frame(1'b1, 0);
      checks++;
      if (bus.o_frames !== 2'd1 || bus.o_enb !== 1'b0) begin
         failures++;
         $display("FAIL single_commit: got frames=%0d enb=%b, required frames=1 enb=0", bus.o_frames, bus.o_enb);
      end
      bus.i_out_ready = 1'b1;
      step();
      exp = exp_q.pop_front();
      checks++;
      if (bus.o_enb !== 1'b1 || {bus.o_last, bus.o_data} !== exp) begin
         failures++;
         $display("FAIL single_first_word: got enb=%b last_data=%h, required enb=1 last_data=%h",
                  bus.o_enb, {bus.o_last, bus.o_data}, exp);
      end
      step();
      collect(4, 100, 1'b1, "single");
      checks++;
      if (bus.o_frames !== 2'd0) begin
         failures++;
         $display("FAIL single_release: got frames=%0d, required 0", bus.o_frames);
      end
   endtask

   task automatic test_back_to_back();
      bus.i_out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         gen_frame(4, 1'b0);
         model_frame();
         send_frame(1'b1, 0);
      end
      checks++;
      if (bus.o_tready !== 1'b0 || bus.o_frames !== 2'd2) begin
         failures++;
         $display("FAIL b2b_full: got tready=%b frames=%0d, required tready=0 frames=2", bus.o_tready, bus.o_frames);
      end
      gen_frame(4, 1'b0);
      model_frame();
      fork
         send_frame(1'b1, 0);
         collect(8, 100, 1'b1, "b2b_first_two");
      join
      collect(4, 100, 1'b0, "b2b_third");
   endtask

   task automatic test_stall();
      int lens[6];
      int total = 0;
      for (int k = 0; k < 6; k++) begin
         lens[k] = (k == 0) ? NW : $urandom_range(NW, 1);
         total += lens[k];
      end
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               gen_frame(lens[k], 1'b0);
               model_frame();
               send_frame(1'b1, 30);
            end
         end
         collect(total, 50, 1'b0, "stall");
      join
   endtask

   task automatic test_overflow();
      int lens[4] = '{NW, NW + 1, 11, 3};
      bit pulse_exp;
      logic [1:0] frames_exp;
      for (int k = 0; k < 4; k++) begin
         gen_frame(lens[k], 1'b0);
         pulse_exp = (frm.size() > NW);
         model_frame();
         frames_exp = (exp_q.size() > 0) ? 2'd1 : 2'd0;
         send_frame(1'b1, 0);
         checks++;
         if (bus.o_overflow !== pulse_exp || bus.o_frames !== frames_exp) begin
            failures++;
            $display("FAIL ovf_len%0d_end: got ovf=%b frames=%0d, required ovf=%b frames=%0d",
                     lens[k], bus.o_overflow, bus.o_frames, pulse_exp, frames_exp);
         end
         step();
         checks++;
         if (bus.o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_len%0d_pulse_width: got ovf=%b, required 0", lens[k], bus.o_overflow);
         end
         collect(exp_q.size(), 100, 1'b1, "ovf");
         repeat (3) step();
         checks++;
         if (bus.o_enb !== 1'b0 || bus.o_frames !== 2'd0 || ovf_cnt !== exp_ovf) begin
            failures++;
            $display("FAIL ovf_len%0d_after: got enb=%b frames=%0d pulses=%0d, required enb=0 frames=0 pulses=%0d",
                     lens[k], bus.o_enb, bus.o_frames, ovf_cnt, exp_ovf);
         end
      end
   endtask

   task automatic test_commit_release();
      logic [8:0] exp;
      bus.i_out_ready = 1'b0;
      gen_frame(3, 1'b0);
      model_frame();
      send_frame(1'b1, 0);
      repeat (3) step();
      checks++;
      if (bus.o_enb !== 1'b1 || bus.o_frames !== 2'd1) begin
         failures++;
         $display("FAIL cr_setup: got enb=%b frames=%0d, required enb=1 frames=1", bus.o_enb, bus.o_frames);
      end
      gen_frame(4, 1'b0);
      model_frame();
      // Consume the held frame so its last handshake lands on the edge that commits the new frame.
      for (int c = 0; c < 4; c++) begin
         bus.i_tdata_valid = 1'b1;
         bus.i_tdata       = frm[c];
         bus.i_tdata_last  = (c == 3);
         bus.i_out_ready   = (c >= 1);
         checks++;
         if (bus.o_tready !== 1'b1) begin
            failures++;
            $display("FAIL cr_tready%0d: got %b, required 1", c, bus.o_tready);
         end
         if (c >= 1) begin
            exp = exp_q.pop_front();
            checks++;
            if (bus.o_enb !== 1'b1 || {bus.o_last, bus.o_data} !== exp) begin
               failures++;
               $display("FAIL cr_word%0d: got enb=%b last_data=%h, required enb=1 last_data=%h",
                        c, bus.o_enb, {bus.o_last, bus.o_data}, exp);
            end
         end
         step();
      end
      bus.i_tdata_valid = 1'b0;
      bus.i_tdata_last  = 1'b0;
      bus.i_out_ready   = 1'b0;
      checks++;
      if (bus.o_frames !== 2'd1) begin
         failures++;
         $display("FAIL cr_frames: got %0d, required 1", bus.o_frames);
      end
      collect(4, 100, 1'b1, "cr_next");
      checks++;
      if (bus.o_frames !== 2'd0) begin
         failures++;
         $display("FAIL cr_drained: got frames=%0d, required 0", bus.o_frames);
      end
   endtask

   task automatic test_reset_mid_frame();
      bus.i_out_ready = 1'b0;
      gen_frame(4, 1'b0);
      model_frame();
      send_frame(1'b1, 0);
      step();
      step();
      gen_frame(3, 1'b0);
      send_frame(1'b0, 0);
      i_rst_n = 1'b0;
      step();
      check_idle_outputs("midreset_state", 1'b0);
      exp_q.delete();
      i_rst_n = 1'b1;
      step();
      checks++;
      if (bus.o_tready !== 1'b1) begin
         failures++;
         $display("FAIL midreset_tready: got %b, required 1", bus.o_tready);
      end
      gen_frame(5, 1'b0);
      model_frame();
      send_frame(1'b1, 0);
      collect(5, 100, 1'b1, "midreset_next");
   endtask

   task automatic test_drained();
      repeat (4) step();
      checks++;
      if (exp_q.size() != 0 || ovf_cnt !== exp_ovf || bus.o_frames !== 2'd0 || bus.o_enb !== 1'b0) begin
         failures++;
         $display("FAIL drained: got pending=%0d pulses=%0d frames=%0d enb=%b, required pending=0 pulses=%0d frames=0 enb=0",
                  exp_q.size(), ovf_cnt, bus.o_frames, bus.o_enb, exp_ovf);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_stall();
      test_overflow();
      test_commit_release();
      test_reset_mid_frame();
      test_drained();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
